// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator: operator codes, sequencer
// states, datapath widths and the fixed latencies of each operation class.
package calc_pkg;

  localparam int OP_W       = 7;
  localparam int RES_W      = 14;
  localparam int BCD_DIGITS = 4;

  localparam logic [3:0] OP_ADD = 4'ha;
  localparam logic [3:0] OP_SUB = 4'hb;
  localparam logic [3:0] OP_MUL = 4'hc;
  localparam logic [3:0] OP_DIV = 4'hd;

  localparam int LAT_ADDSUB = 17;
  localparam int LAT_MULDIV = 23;
  localparam int LAT_ERR    = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXEC,
    BCD,
    DONE
  } state_t;

  // Two BCD digits to binary; digits above 9 are rejected separately.
  function automatic logic [OP_W-1:0] bcdToBin(input logic [3:0] hi, input logic [3:0] lo);
    return ({3'b000, hi} * 7'd10) + {3'b000, lo};
  endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble: the start cycle loads the binary value and performs
// the first shift, so all RES_W shifts are done and done_o pulses RES_W cycles later.
module calc_bin2bcd
  import calc_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [RES_W-1:0]        bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);

  logic [4*BCD_DIGITS-1:0]       bcd_q;
  logic [RES_W-1:0]              bin_q;
  logic [3:0]                    cnt_q;
  logic                          busy_q;
  logic                          done_q;
  logic                          startOk;
  logic [4*BCD_DIGITS-1:0]       bcdSrc;
  logic [4*BCD_DIGITS-1:0]       bcdAdj;
  logic [RES_W-1:0]              binSrc;
  logic [4*BCD_DIGITS+RES_W-1:0] shifted;

  assign startOk = start_i && !busy_q;

  always_comb begin
    bcdSrc = startOk ? '0 : bcd_q;
    binSrc = startOk ? bin_i : bin_q;
    bcdAdj = bcdSrc;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcdSrc[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcdSrc[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcdAdj, binSrc} << 1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (startOk || busy_q) begin
        bcd_q <= shifted[4*BCD_DIGITS+RES_W-1:RES_W];
        bin_q <= shifted[RES_W-1:0];
      end
      if (startOk) begin
        cnt_q  <= 4'd1;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (cnt_q == 4'(RES_W - 1)) begin
          cnt_q  <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/calc_alu_seq.sv
// Multi-cycle calculator sequencer: latches two BCD operands and an operator,
// computes +, -, * (shift-add) or / (restoring), then converts the result to BCD.
module calc_alu_seq
  import calc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] a_hi_i,
  input  logic [3:0] a_lo_i,
  input  logic [3:0] b_hi_i,
  input  logic [3:0] b_lo_i,
  input  logic [3:0] op_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] res_d3_o,
  output logic [3:0] res_d2_o,
  output logic [3:0] res_d1_o,
  output logic [3:0] res_d0_o,
  output logic       res_neg_o,
  output logic       res_err_o
);

  state_t                  state_q;
  logic                    busy_q, done_q;
  logic [4*BCD_DIGITS-1:0] resBcd_q;
  logic                    resNeg_q, resErr_q;
  logic [3:0]              aHi_q, aLo_q, bHi_q, bLo_q, op_q;
  logic [OP_W-1:0]         opA_q, opB_q, rem_q;
  logic [RES_W-1:0]        acc_q;
  logic [2:0]              cnt_q;
  logic                    neg_q;

  logic [OP_W-1:0]         aBin, bBin, remNext;
  logic [OP_W:0]           trial;
  logic [RES_W-1:0]        rNext;
  logic                    loadErr, lastExec, bcdStart, bcdBusy, bcdDone;
  logic [4*BCD_DIGITS-1:0] bcdVal;

  always_comb begin
    aBin    = bcdToBin(aHi_q, aLo_q);
    bBin    = bcdToBin(bHi_q, bLo_q);
    loadErr = (aHi_q > 4'd9) || (aLo_q > 4'd9) || (bHi_q > 4'd9) || (bLo_q > 4'd9) ||
              !(op_q inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV}) ||
              ((op_q == OP_DIV) && (bBin == '0));
  end

  // One EXEC step: add/sub finish at once, mul adds A<<i for bit i of B,
  // div brings down A's bits MSB first and shifts quotient bits into acc.
  always_comb begin
    rNext   = acc_q;
    remNext = rem_q;
    trial   = '0;
    case (op_q)
      OP_ADD: rNext = RES_W'(opA_q) + RES_W'(opB_q);
      OP_SUB: rNext = (opA_q >= opB_q) ? RES_W'(opA_q - opB_q) : RES_W'(opB_q - opA_q);
      OP_MUL: begin
        if (opB_q[cnt_q]) begin
          rNext = acc_q + (RES_W'(opA_q) << cnt_q);
        end
      end
      OP_DIV: begin
        trial = {rem_q, opA_q[3'(OP_W - 1) - cnt_q]};
        if (trial >= {1'b0, opB_q}) begin
          remNext = OP_W'(trial - {1'b0, opB_q});
          rNext   = {acc_q[RES_W-2:0], 1'b1};
        end else begin
          remNext = trial[OP_W-1:0];
          rNext   = {acc_q[RES_W-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  assign lastExec = (op_q == OP_ADD) || (op_q == OP_SUB) || (cnt_q == 3'(OP_W - 1));
  assign bcdStart = (state_q == EXEC) && lastExec && !bcdBusy;

  calc_bin2bcd u_bin2bcd (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (bcdStart),
    .bin_i   (rNext),
    .busy_o  (bcdBusy),
    .done_o  (bcdDone),
    .bcd_o   (bcdVal)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      resBcd_q <= '0;
      resNeg_q <= 1'b0;
      resErr_q <= 1'b0;
      aHi_q    <= '0;
      aLo_q    <= '0;
      bHi_q    <= '0;
      bLo_q    <= '0;
      op_q     <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            aHi_q   <= a_hi_i;
            aLo_q   <= a_lo_i;
            bHi_q   <= b_hi_i;
            bLo_q   <= b_lo_i;
            op_q    <= op_i;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (loadErr) begin
            resBcd_q <= '0;
            resNeg_q <= 1'b0;
            resErr_q <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            resNeg_q <= 1'b0;
            resErr_q <= 1'b0;
            opA_q    <= aBin;
            opB_q    <= bBin;
            rem_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          acc_q <= rNext;
          rem_q <= remNext;
          cnt_q <= cnt_q + 3'd1;
          neg_q <= (op_q == OP_SUB) && (opA_q < opB_q);
          if (lastExec) begin
            state_q <= BCD;
          end
        end
        BCD: begin
          if (bcdDone) begin
            resBcd_q <= bcdVal;
            resNeg_q <= neg_q;
            resErr_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign res_d3_o  = resBcd_q[15:12];
  assign res_d2_o  = resBcd_q[11:8];
  assign res_d1_o  = resBcd_q[7:4];
  assign res_d0_o  = resBcd_q[3:0];
  assign res_neg_o = resNeg_q;
  assign res_err_o = resErr_q;

endmodule

// File: doc/calc_alu_seq.md
Name: calc_alu_seq

Overview:
- Multi-cycle arithmetic sequencer for the keypad calculator.
- Accepts two 2-digit BCD operands and an operator code from the key-entry state machine, computes the result, and converts it to 4 BCD digits.
- Operators are +, -, * and /. Multiply and divide are iterative shift-add / restoring-divide loops.
- Drives the result digits, sign and error flags consumed by the seg_data_* update logic on the '=' key.

Parameters:
OP_W, 7, binary operand width (max operand 99)
RES_W, 14, binary result width (max 9801)
BCD_DIGITS, 4, number of result BCD digits

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request; sampled only when busy=0
a_hi  input  4  operand A tens digit (BCD)
a_lo  input  4  operand A units digit (BCD)
b_hi  input  4  operand B tens digit (BCD)
b_lo  input  4  operand B units digit (BCD)
op  input  4  operator: 4'ha=+, 4'hb=-, 4'hc=*, 4'hd=/
busy  output  1  high from cycle after start acceptance until DONE inclusive
done  output  1  one-cycle pulse; results valid from this cycle
res_d3..res_d0  output  4 each  result thousands..units (BCD)
res_neg  output  1  result negative (subtraction with A<B)
res_err  output  1  divide-by-zero, non-BCD digit (>9), or op outside a..d

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, res_d*=0, res_neg=0, res_err=0, all internal registers 0. Reset mid-operation aborts to IDLE with the same values.
- States: IDLE -> LOAD -> EXEC -> BCD -> DONE -> IDLE. Error path: LOAD -> DONE.
- IDLE: start=1 latches inputs and goes to LOAD; busy rises next cycle. start while busy=1 is ignored (no queueing).
- LOAD (1 cycle):
  - A = a_hi*10 + a_lo and B = b_hi*10 + b_lo, each OP_W bits.
  - If any digit >9, op not in a..d, or (op=d and B=0): set err, go to DONE.
  - Otherwise clear res_neg/res_err and go to EXEC.
- EXEC, 1 cycle for + and -:
  - + : R = A+B.
  - - : if A>=B, R = A-B and neg=0; else R = B-A and neg=1.
- EXEC, exactly OP_W=7 cycles for * and /, counter 0..6:
  - * : shift-add; each cycle examines one bit of B, LSB first; R = A*B.
  - / : restoring division, MSB first; R = quotient floor(A/B); remainder discarded.
- BCD: sequential double-dabble over RES_W=14 bits, exactly 14 cycles. Add-3 correction on every nibble >=5 before each shift.
- DONE (1 cycle):
  - done=1; res_d3..d0, res_neg and res_err update in this cycle and are held until the next accepted start.
  - On error: res_d*=0, res_neg=0, res_err=1.
- Latency, counting the start-sample cycle as 0 (done high in cycle):
  - 17 for + and -.
  - 23 for * and /.
  - 2 for any error.
- busy=1 for cycles 1..done-cycle. A new start may be sampled in the cycle after DONE (IDLE).
- Width rules:
  - All intermediate values are unsigned; no overflow is possible (max 9801 < 2^14).
  - Subtraction magnitude is never negative in R.

Decomposition:
- Shared package calc_pkg holds:
  - Operator codes OP_ADD=4'ha, OP_SUB=4'hb, OP_MUL=4'hc, OP_DIV=4'hd; also used by the key mapping.
  - State enumeration for IDLE/LOAD/EXEC/BCD/DONE.
  - Latency constants LAT_ADDSUB=17, LAT_MULDIV=23, LAT_ERR=2.
- One sub-module: calc_bin2bcd. Sequential 14-bit double-dabble with ports start/bin/busy/done/bcd[15:0]; instantiated for the BCD state.

Test Plan:
- A=12, B=34, op=a, start -> done in cycle 17; res=0,0,4,6; neg=0; err=0; busy high cycles 1..17.
- A=05, B=17, op=b -> done in cycle 17; res=0,0,1,2; neg=1. Then A=17, B=05, op=b -> 0,0,1,2, neg=0.
- A=99, B=99, op=c -> done in cycle 23; res=9,8,0,1. Then A=87, B=05, op=d -> 0,0,1,7. Then A=07, B=09, op=d -> 0,0,0,0.
- A=42, B=00, op=d -> done in cycle 2; err=1; res=0,0,0,0. Then a_lo=4'hb with op=a -> err=1. Then op=4'he -> err=1.
- Start pulse at cycles 5 and 10 during an active multiply -> both ignored; exactly one done in cycle 23; results unchanged until the next accepted start.
- rst=1 in cycle 8 of a divide -> next cycle busy=0, done=0, res=0, flags 0. A fresh start then completes with correct latency.
